// File: rtl/adc_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : adc_arbiter
// Brief    : Round-robin arbiter granting 4 requesters on-demand ADC
//            conversions by freezing the ADC control block on one channel.
//            Optional watchdog: define ADC_ARB_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module adc_arbiter (
    input  logic        SCK,
    input  logic        POR,
    input  logic [3:0]  req,
    input  logic [11:0] req_ch,
    input  logic        adc_sample,
    input  logic [9:0]  adc_data,
    output logic        adc_freeze,
    output logic [2:0]  adc_fchannel,
    output logic [3:0]  gnt,
    output logic [3:0]  ack,
    output logic [9:0]  rdata,
    output logic        err,
    output logic        busy
);

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_ARM  = 4'b0010,
        S_CONV = 4'b0100,
        S_DONE = 4'b1000
    } state_t;

    state_t      r_state;
    logic [1:0]  r_last;
    logic [3:0]  r_gnt;
    logic [3:0]  r_ack;
    logic        r_freeze;
    logic [2:0]  r_fch;
    logic [9:0]  r_rdata;

    logic        w_found;
    logic [1:0]  w_win;
    logic [1:0]  w_idx;
    logic [2:0]  w_ch;
    logic        w_tmo;

    // Search from the requester after the last winner so the last winner is
    // considered last.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_last;
        w_idx   = r_last;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_last + 2'(k);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        case (w_win)
            2'd0:    w_ch = req_ch[2:0];
            2'd1:    w_ch = req_ch[5:3];
            2'd2:    w_ch = req_ch[8:6];
            default: w_ch = req_ch[11:9];
        endcase
    end

`ifdef ADC_ARB_TIMEOUT_EN
    logic [7:0] r_wdog;
    logic       r_err;

    assign w_tmo = (r_wdog == 8'hFF);

    // Held at zero while idle, so it starts from zero on ARM entry.
    always_ff @(posedge SCK) begin
        if (!POR) begin
            r_wdog <= 8'h00;
        end else if (r_state == S_IDLE || adc_sample) begin
            r_wdog <= 8'h00;
        end else if (r_state == S_ARM || r_state == S_CONV) begin
            r_wdog <= r_wdog + 8'h01;
        end
    end

    always_ff @(posedge SCK) begin
        if (!POR) begin
            r_err <= 1'b0;
        end else begin
            r_err <= (r_state == S_ARM || r_state == S_CONV) && !adc_sample && w_tmo;
        end
    end

    assign err = r_err;
`else
    assign w_tmo = 1'b0;
    assign err   = 1'b0;
`endif

    always_ff @(posedge SCK) begin
        if (!POR) begin
            r_state  <= S_IDLE;
            r_last   <= 2'd3;
            r_gnt    <= 4'b0000;
            r_ack    <= 4'b0000;
            r_freeze <= 1'b0;
            r_fch    <= 3'd0;
            r_rdata  <= 10'd0;
        end else begin
            r_ack <= 4'b0000;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state  <= S_ARM;
                        r_gnt    <= 4'b0001 << w_win;
                        r_freeze <= 1'b1;
                        r_fch    <= w_ch;
                        r_last   <= w_win;
                    end
                end
                S_ARM: begin
                    if (adc_sample) begin
                        r_state <= S_CONV;
                    end else if (w_tmo) begin
                        r_state  <= S_DONE;
                        r_ack    <= r_gnt;
                        r_gnt    <= 4'b0000;
                        r_freeze <= 1'b0;
                    end
                end
                S_CONV: begin
                    if (adc_sample || w_tmo) begin
                        r_state  <= S_DONE;
                        r_ack    <= r_gnt;
                        r_gnt    <= 4'b0000;
                        r_freeze <= 1'b0;
                        if (adc_sample) begin
                            r_rdata <= adc_data;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign adc_freeze   = r_freeze;
    assign adc_fchannel = r_fch;
    assign gnt          = r_gnt;
    assign ack          = r_ack;
    assign rdata        = r_rdata;
    assign busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_adc_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_arbiter
// Brief    : Directed bench for adc_arbiter with a transaction-level model.
// Revision : 1.0
// ============================================================================
module tb_adc_arbiter;

    logic        SCK;
    logic        POR;
    logic [3:0]  req;
    logic [11:0] req_ch;
    logic        adc_sample;
    logic [9:0]  adc_data;
    logic        adc_freeze;
    logic [2:0]  adc_fchannel;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [9:0]  rdata;
    logic        err;
    logic        busy;

    adc_arbiter dut (
        .SCK          (SCK),
        .POR          (POR),
        .req          (req),
        .req_ch       (req_ch),
        .adc_sample   (adc_sample),
        .adc_data     (adc_data),
        .adc_freeze   (adc_freeze),
        .adc_fchannel (adc_fchannel),
        .gnt          (gnt),
        .ack          (ack),
        .rdata        (rdata),
        .err          (err),
        .busy         (busy)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Model: who owns the ADC, how many samples seen, how long waited.
    int         m_owner   = -1;
    int         m_samples = 0;
    int         m_wait    = 0;
    int         m_last    = 3;
    bit         m_done    = 1'b0;
    logic [3:0] e_gnt     = 4'b0;
    logic [3:0] e_ack     = 4'b0;
    logic [9:0] e_rdata   = 10'b0;
    logic       e_err     = 1'b0;
    logic       e_frz     = 1'b0;
    logic [2:0] e_ch      = 3'b0;

    initial begin
        SCK = 1'b0;
        forever #5 SCK = ~SCK;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic finish_txn(input bit timed_out);
        e_ack   = 4'(1 << m_owner);
        e_err   = timed_out;
        e_gnt   = 4'b0;
        e_frz   = 1'b0;
        m_owner = -1;
        m_done  = 1'b1;
    endtask

    task automatic model_step();
        if (!POR) begin
            m_owner = -1; m_done = 1'b0; m_last = 3;
            e_gnt = 4'b0; e_ack = 4'b0; e_err = 1'b0;
            e_frz = 1'b0; e_ch = 3'b0; e_rdata = 10'b0;
        end else if (m_done) begin
            m_done = 1'b0; e_ack = 4'b0; e_err = 1'b0;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= 4; k++) begin
                int i;
                i = (m_last + k) % 4;
                if (m_owner < 0 && req[i]) m_owner = i;
            end
            if (m_owner >= 0) begin
                m_last    = m_owner;
                e_gnt     = 4'(1 << m_owner);
                e_frz     = 1'b1;
                e_ch      = req_ch[3*m_owner +: 3];
                m_samples = 0;
                m_wait    = 0;
            end
        end else begin
            if (adc_sample) begin
                m_samples++;
                m_wait = 0;
                if (m_samples == 2) begin
                    e_rdata = adc_data;
                    finish_txn(1'b0);
                end
            end
`ifdef ADC_ARB_TIMEOUT_EN
            else if (m_wait == 255) finish_txn(1'b1);
            else m_wait++;
`endif
        end
    endtask

    initial forever begin
        @(posedge SCK);
        model_step();
    end

    initial forever begin
        @(negedge SCK);
        if (chk_en) begin
            chk("cycle_outputs",
                {8'b0, gnt, ack, rdata, err, busy, adc_freeze, adc_fchannel},
                {8'b0, e_gnt, e_ack, e_rdata, e_err, (m_owner >= 0 || m_done), e_frz, e_ch});
        end
    end

    task automatic tick();
        @(negedge SCK);
    endtask

    logic [3:0] seq [5];
    logic [3:0] exp_seq [5];
    logic [3:0] prev;
    int         n;

    initial begin
        POR = 1'b0; req = 4'b0; req_ch = 12'b0; adc_sample = 1'b0; adc_data = 10'b0;
        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
        exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
        for (int k = 0; k < 5; k++) seq[k] = 4'b0;
        repeat (3) tick();
        chk_en = 1'b1;
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_rdata", 32'(rdata), 32'h0);
        POR = 1'b1;

        // Single fastest transaction, sample in DONE ignored
        req = 4'b0001; req_ch = 12'h005;
        tick();
        chk("t1_freeze", 32'(adc_freeze), 32'h1);
        chk("t1_fchannel", 32'(adc_fchannel), 32'h5);
        adc_sample = 1'b1; adc_data = 10'h2A5;
        tick();
        req = 4'b0;
        tick();
        chk("t1_ack", 32'(ack), 32'h1);
        chk("t1_rdata", 32'(rdata), 32'h2A5);
        tick();
        chk("t1_no_second_ack", 32'(ack), 32'h0);
        chk("t1_idle", 32'(busy), 32'h0);
        chk("t1_fch_hold", 32'(adc_fchannel), 32'h5);
        adc_sample = 1'b0;
        tick();

        // Round robin from reset with all requesters active
        POR = 1'b0;
        tick();
        POR = 1'b1; req = 4'b1111; req_ch = 12'o7531; adc_sample = 1'b1;
        n = 0; prev = 4'b0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            tick();
            adc_data = 10'(c * 37 + 1);
            if (gnt != 4'b0 && prev == 4'b0) begin
                seq[n] = gnt;
                n++;
            end
            prev = gnt;
        end
        chk("rr_count", 32'(n), 32'd5);
        for (int k = 0; k < 5; k++) chk("rr_order", 32'(seq[k]), 32'(exp_seq[k]));
        req = 4'b0;
        for (int c = 0; c < 10 && busy; c++) tick();
        chk("rr_drain", 32'(busy), 32'h0);
        adc_sample = 1'b0;
        tick();

        // Requester drops in CONV, still acknowledged
        req = 4'b0100; req_ch = 12'h180;
        tick();
        chk("t3_gnt", 32'(gnt), 32'h4);
        adc_sample = 1'b1;
        tick();
        adc_sample = 1'b0; req = 4'b0;
        repeat (3) tick();
        chk("t3_wait_busy", 32'(busy), 32'h1);
        adc_sample = 1'b1; adc_data = 10'h155;
        tick();
        chk("t3_ack", 32'(ack), 32'h4);
        chk("t3_rdata", 32'(rdata), 32'h155);
        adc_sample = 1'b0;
        tick();
        chk("t3_gnt_clear", 32'(gnt), 32'h0);
        chk("t3_busy_clear", 32'(busy), 32'h0);

        // Reset in CONV abandons the transaction
        req = 4'b0010; req_ch = 12'h038;
        tick();
        adc_sample = 1'b1;
        tick();
        adc_sample = 1'b0;
        tick();
        POR = 1'b0;
        tick();
        chk("t4_reset_outputs",
            {8'b0, gnt, ack, rdata, err, busy, adc_freeze, adc_fchannel}, 32'h0);
        POR = 1'b1;
        tick();
        chk("t4_regrant", 32'(gnt), 32'h2);
        chk("t4_fchannel", 32'(adc_fchannel), 32'h7);
        adc_sample = 1'b1; adc_data = 10'h0F0;
        tick();
        req = 4'b0;
        tick();
        chk("t4_ack", 32'(ack), 32'h2);
        adc_sample = 1'b0;
        tick();

        // No samples after grant
        req = 4'b0001; req_ch = 12'h003;
        tick();
        req = 4'b0;
`ifdef ADC_ARB_TIMEOUT_EN
        repeat (255) tick();
        chk("t5_pre_ack", 32'(ack), 32'h0);
        chk("t5_pre_busy", 32'(busy), 32'h1);
        tick();
        chk("t5_ack", 32'(ack), 32'h1);
        chk("t5_err", 32'(err), 32'h1);
        chk("t5_rdata_kept", 32'(rdata), 32'h0F0);
        tick();
        chk("t5_err_clear", 32'(err), 32'h0);
        chk("t5_idle", 32'(busy), 32'h0);
`else
        repeat (300) tick();
        chk("t5_busy_hold", 32'(busy), 32'h1);
        chk("t5_no_err", 32'(err), 32'h0);
        chk("t5_no_ack", 32'(ack), 32'h0);
        POR = 1'b0;
        tick();
        POR = 1'b1;
        tick();
`endif
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc_arbiter.md
ADC_ARBITER -- requirements
Module: adc_arbiter

Interface
REQ-001 SHALL: SCK  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL: POR  in  1  reset, synchronous, active-low; sampled on SCK rising edge only.
REQ-003 SHALL: req  in  4  per-requester on-demand conversion request; req[i] is held high until ack[i].
REQ-004 SHALL: req_ch  in  12  requested channel; requester i uses bits [3i+2:3i].
REQ-005 SHALL: adc_sample  in  1  one-cycle sample strobe from the ADC control block.
REQ-006 SHALL: adc_data  in  10  conversion result, valid in the adc_sample cycle.
REQ-007 SHALL: adc_freeze  out  1  registered; holds the ADC control block on adc_fchannel.
REQ-008 SHALL: adc_fchannel  out  3  registered; channel to freeze on.
REQ-009 SHALL: gnt  out  4  registered one-hot grant; all zero when idle.
REQ-010 SHALL: ack  out  4  registered one-cycle completion pulse to the granted requester.
REQ-011 SHALL: rdata  out  10  registered result; valid in the ack cycle, held until the next completion.
REQ-012 SHALL: err  out  1  registered; pulses with ack on timeout abort (see Configuration).
REQ-013 SHALL: busy  out  1  high whenever state is not IDLE.

Function
REQ-014 SHALL: FSM states IDLE, ARM, CONV, DONE, one-hot encoded.
REQ-015 SHALL: IDLE with any req bit high -> ARM next cycle; gnt, adc_freeze=1 and adc_fchannel=req_ch of the winner are registered on that same edge.
REQ-016 SHALL: arbitration is round-robin; search starts at (last_gnt+1) mod 4; last_gnt updates on each grant.
REQ-017 SHALL: ARM: adc_sample high -> CONV (that sample latches the freeze); otherwise remain in ARM.
REQ-018 SHALL: CONV: adc_sample high -> DONE, rdata <= adc_data on the same edge; otherwise remain in CONV.
REQ-019 SHALL: DONE lasts exactly one cycle: ack[granted]=1, gnt=0, adc_freeze=0; next state IDLE.
REQ-020 SHALL: adc_fchannel holds its last value when adc_freeze=0.
REQ-021 SHALL: req[i] dropping while granted does not abort; the transaction completes and ack[i] still pulses.
REQ-022 SHALL: req changes and req_ch changes after grant are ignored until IDLE.
REQ-023 SHALL: a requester keeping req high through ack is re-arbitrated from IDLE with lowest priority relative to the others.
REQ-024 SHALL: minimum request-to-ack latency is 3 cycles (IDLE->ARM->CONV->DONE with adc_sample in the first ARM and first CONV cycles); otherwise unbounded without timeout.
REQ-025 SHALL: at most one ack bit is high in any cycle; gnt is always zero or one-hot.

Reset
REQ-026 SHALL: POR low -> state IDLE, gnt=0, ack=0, err=0, busy=0, adc_freeze=0, adc_fchannel=0, rdata=0, last_gnt=3 (req[0] wins first).
REQ-027 SHALL: reset mid-transaction abandons it silently; no ack or err is issued.

Configuration
REQ-028 SHALL: macro ADC_ARB_TIMEOUT_EN compiles in an 8-bit watchdog.
REQ-029 SHALL (defined): counter clears on entry to ARM and on every adc_sample, increments in ARM/CONV; at 255 -> DONE with err=1, rdata unchanged, ack still pulsed.
REQ-030 SHALL (undefined): no counter logic; err tied 0; ARM/CONV wait indefinitely.

Verification
REQ-031 SHALL: req=4'b0001, req_ch[2:0]=5, adc_sample in first ARM and first CONV cycle with adc_data=10'h2A5 -> adc_freeze=1, adc_fchannel=5, ack=4'b0001 and rdata=10'h2A5 on cycle 3.
REQ-032 SHALL: req=4'b1111 held continuously -> grants in order 0,1,2,3,0 with no requester granted twice consecutively.
REQ-033 SHALL: req[2] dropped in CONV -> ack[2] still pulses at next adc_sample; then gnt=0 and busy=0.
REQ-034 SHALL: POR low during CONV -> next cycle all outputs at reset values, no ack; after release req[1] granted normally.
REQ-035 SHALL: with ADC_ARB_TIMEOUT_EN, no adc_sample after grant -> ack and err pulse exactly 256 cycles after ARM entry, rdata unchanged; without the macro, busy stays high.
REQ-036 SHALL: adc_sample high in the DONE cycle -> ignored; state IDLE next cycle, no second ack.
